lae_ctrl: RTL and testbench

LAE_CTRL -- requirements
Module: lae_ctrl

---
 rtl/lae_pkg.sv | 26 ++
 rtl/lae_ctrl_if.sv | 32 +++
 rtl/lae_rcon_lfsr.sv | 36 +++
 rtl/lae_ctrl.sv | 130 +++++++++++++
 tb/tb_lae_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lae_pkg.sv
// Shared definitions for the LAE round controller: state codes, round-constant
// seed and step function, and default round counts.
package lae_pkg;

    localparam int unsigned DEF_INIT_ROUNDS  = 24;
    localparam int unsigned DEF_FINAL_ROUNDS = 24;

    localparam int unsigned RCNT_W = 5;
    localparam int unsigned RCON_W = 6;

    localparam logic [RCON_W-1:0] RCON_INIT = 6'h01;

    // FSM state encoding
    typedef logic [2:0] lae_state_t;
    localparam lae_state_t ST_IDLE   = 3'd0;
    localparam lae_state_t ST_INIT   = 3'd1;
    localparam lae_state_t ST_ABSORB = 3'd2;
    localparam lae_state_t ST_FINAL  = 3'd3;
    localparam lae_state_t ST_TAG    = 3'd4;

    // x^6 + x^5 + 1 is primitive, so the register cycles through all 63 non-zero values.
    function automatic logic [RCON_W-1:0] rcon_step(input logic [RCON_W-1:0] r);
        return {r[4:0], r[5] ^ r[4]};
    endfunction

endpackage

// File: rtl/lae_ctrl_if.sv
// Block handshake and datapath control bundle between the session source and
// the LAE controller.
interface lae_ctrl_if;
    import lae_pkg::*;

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_type;
    logic              in_last;
    logic              init;
    logic              getdata;
    logic              outc;
    logic              final_o;
    logic [RCON_W-1:0] rcon;
    logic              round_en;
    logic              busy;
    logic              tag_valid;

    // Session source side
    modport master (
        output start, in_valid, in_type, in_last,
        input  in_ready, init, getdata, outc, final_o, rcon, round_en, busy, tag_valid
    );

    // Controller side
    modport slave (
        input  start, in_valid, in_type, in_last,
        output in_ready, init, getdata, outc, final_o, rcon, round_en, busy, tag_valid
    );

endinterface

// File: rtl/lae_rcon_lfsr.sv
// 6-bit round-constant LFSR: load reseeds to RCON_INIT, enable steps once.
module lae_rcon_lfsr
    import lae_pkg::*;
(
    input  logic              ck,
    input  logic              rst,
    input  logic              en_i,
    input  logic              load_i,
    output logic [RCON_W-1:0] rcon_o
);

    logic [RCON_W-1:0] rcon_q;
    logic [RCON_W-1:0] rcon_d;

    // Next value: reseed wins over step, otherwise hold
    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (en_i) begin
            rcon_d = rcon_step(rcon_q);
        end
    end

    // Constant register with synchronous reset to the seed
    always_ff @(posedge ck) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/lae_ctrl.sv
// LAE session controller: sequences init rounds, block absorption, finalisation
// rounds and the one-cycle tag release for the round datapath.
module lae_ctrl
    import lae_pkg::*;
#(
    // Both counts must lie in 1..32 to fit the 5-bit round counter.
    parameter int unsigned INIT_ROUNDS  = DEF_INIT_ROUNDS,
    parameter int unsigned FINAL_ROUNDS = DEF_FINAL_ROUNDS
) (
    input  logic        ck,
    input  logic        rst,
    lae_ctrl_if.slave   bus
);

    localparam logic [RCNT_W-1:0] INIT_LAST  = RCNT_W'(INIT_ROUNDS - 1);
    localparam logic [RCNT_W-1:0] FINAL_LAST = RCNT_W'(FINAL_ROUNDS - 1);

    lae_state_t        state_q;
    lae_state_t        state_d;
    logic [RCNT_W-1:0] rcnt_q;
    logic [RCNT_W-1:0] rcnt_d;
    logic              rcon_load;
    logic              round_en;

    // Next-state and round-counter update
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rcon_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_INIT;
                    rcnt_d    = '0;
                    rcon_load = 1'b1;
                end
            end
            ST_INIT: begin
                if (rcnt_q == INIT_LAST) begin
                    state_d = ST_ABSORB;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_ABSORB: begin
                if (bus.in_valid && bus.in_last) begin
                    state_d = ST_FINAL;
                    rcnt_d  = '0;
                end
            end
            ST_FINAL: begin
                if (rcnt_q == FINAL_LAST) begin
                    state_d = ST_TAG;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_TAG: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    // State and counter registers, synchronous reset has top priority
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Output decode from registered state plus the current block qualifiers
    always_comb begin
        bus.init      = 1'b0;
        bus.getdata   = 1'b0;
        bus.outc      = 1'b0;
        bus.final_o   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.tag_valid = 1'b0;
        round_en      = 1'b0;
        case (state_q)
            ST_INIT: begin
                bus.busy = 1'b1;
                round_en = 1'b1;
                bus.init = (rcnt_q == '0);
            end
            ST_ABSORB: begin
                bus.busy     = 1'b1;
                bus.in_ready = 1'b1;
                // A round only happens when a block is actually delivered
                round_en     = bus.in_valid;
                bus.getdata  = bus.in_valid;
                bus.outc     = bus.in_valid & bus.in_type;
            end
            ST_FINAL: begin
                bus.busy = 1'b1;
                round_en = 1'b1;
            end
            ST_TAG: begin
                bus.busy      = 1'b1;
                bus.final_o   = 1'b1;
                bus.tag_valid = 1'b1;
            end
            default: begin
                round_en = 1'b0;
            end
        endcase
    end

    assign bus.round_en = round_en;

    lae_rcon_lfsr u_rcon (
        .ck     (ck),
        .rst    (rst),
        .en_i   (round_en),
        .load_i (rcon_load),
        .rcon_o (bus.rcon)
    );

endmodule

// File: tb/tb_lae_ctrl.sv
// Directed scoreboard bench for lae_ctrl: each cycle pushes the expected output
// vector when inputs are driven and pops it when outputs are sampled.
module tb_lae_ctrl;

    logic ck = 1'b0;
    logic rst;

    always #5 ck = ~ck;

    lae_ctrl_if bus ();

    lae_ctrl #(
        .INIT_ROUNDS  (24),
        .FINAL_ROUNDS (24)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;
    int unsigned cyc       = 0;
    int unsigned gd_cnt    = 0;
    int unsigned oc_cnt    = 0;
    int unsigned tag_cnt   = 0;
    int unsigned tag_cyc   = 0;
    int unsigned blk_cyc   = 0;

    logic [13:0] sb[$];
    logic [5:0]  m_rcon;
    logic [5:0]  rcon_tbl[6];

    // Reference LFSR: shift left, new LSB is the xor of the two top bits
    function automatic logic [5:0] tb_step(input logic [5:0] r);
        logic [5:0] n;
        n    = r << 1;
        n[0] = r[5] ^ r[4];
        return n;
    endfunction

    // {init, getdata, outc, final_o, round_en, busy, tag_valid, in_ready, rcon}
    function automatic logic [13:0] pk(input logic i, g, o, f, re, b, tv, rd,
                                       input logic [5:0] rc);
        return {i, g, o, f, re, b, tv, rd, rc};
    endfunction

    task automatic tick(input string tag, input logic r, s, v, ty, l, input logic [13:0] e);
        logic [13:0] obs;
        logic [13:0] exp_v;
        @(posedge ck);
        #1;
        rst          = r;
        bus.start    = s;
        bus.in_valid = v;
        bus.in_type  = ty;
        bus.in_last  = l;
        sb.push_back(e);
        @(negedge ck);
        cyc++;
        obs = {bus.init, bus.getdata, bus.outc, bus.final_o, bus.round_en, bus.busy,
               bus.tag_valid, bus.in_ready, bus.rcon};
        exp_v = sb.pop_front();
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
        if (bus.getdata === 1'b1) gd_cnt++;
        if (bus.outc === 1'b1) oc_cnt++;
        if (bus.tag_valid === 1'b1) begin
            tag_cnt++;
            tag_cyc = cyc;
        end
    endtask

    task automatic do_idle(input string tag, input logic s);
        tick(tag, 1'b0, s, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, m_rcon));
        if (s) m_rcon = 6'h01;
    endtask

    task automatic do_init(input string tag, input logic s, input logic v);
        for (int i = 0; i < 24; i++) begin
            tick(tag, 1'b0, s, v, 1'b0, 1'b0, pk(i == 0, 0, 0, 0, 1, 1, 0, 0, m_rcon));
            if (i < 6) begin
                n_asserts++;
                assert (bus.rcon === rcon_tbl[i]) else begin
                    n_fail++;
                    $error("FAIL init_rcon_seq i=%0d observed=%h expected=%h",
                           i, bus.rcon, rcon_tbl[i]);
                end
            end
            m_rcon = tb_step(m_rcon);
        end
    endtask

    task automatic do_absorb(input string tag, input logic s, v, ty, l);
        tick(tag, 1'b0, s, v, ty, l, pk(0, v, v & ty, 0, v, 1, 0, 1, m_rcon));
        if (v) m_rcon = tb_step(m_rcon);
        if (v && l) blk_cyc = cyc;
    endtask

    task automatic do_final(input string tag, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            tick(tag, 1'b0, s, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 1, 1, 0, 0, m_rcon));
            m_rcon = tb_step(m_rcon);
        end
    endtask

    task automatic do_tag(input string tag, input logic s);
        tick(tag, 1'b0, s, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 1, 0, 1, 1, 0, m_rcon));
    endtask

    task automatic check_cnt(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        rcon_tbl[0] = 6'h01;
        rcon_tbl[1] = 6'h02;
        rcon_tbl[2] = 6'h04;
        rcon_tbl[3] = 6'h08;
        rcon_tbl[4] = 6'h10;
        rcon_tbl[5] = 6'h21;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_type  = 1'b0;
        bus.in_last  = 1'b0;
        m_rcon       = 6'h01;

        // Reset, with in_valid asserted to show it has no effect
        tick("reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 6'h01));
        tick("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 6'h01));
        do_idle("idle", 1'b0);

        // Session 1: three AD blocks with a 10-cycle gap, then two MSG blocks
        do_idle("idle_start1", 1'b1);
        gd_cnt  = 0;
        oc_cnt  = 0;
        tag_cnt = 0;
        do_init("init1", 1'b0, 1'b0);
        do_absorb("ad1", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) do_absorb("gap", 1'b0, 1'b0, 1'b0, 1'b0);
        do_absorb("ad2", 1'b0, 1'b1, 1'b0, 1'b0);
        do_absorb("ad3", 1'b0, 1'b1, 1'b0, 1'b0);
        do_absorb("msg1", 1'b0, 1'b1, 1'b1, 1'b0);
        do_absorb("msg2_last", 1'b0, 1'b1, 1'b1, 1'b1);
        do_final("final1", 1'b0, 24);
        do_tag("tag1", 1'b0);
        do_idle("idle_after1", 1'b0);
        check_cnt("s1_getdata", gd_cnt, 5);
        check_cnt("s1_outc", oc_cnt, 2);
        check_cnt("s1_tag", tag_cnt, 1);

        // Session 2: reset lands on FINAL round 7
        do_idle("idle_start2", 1'b1);
        do_init("init2", 1'b0, 1'b0);
        do_absorb("ad_last2", 1'b0, 1'b1, 1'b0, 1'b1);
        do_final("final2", 1'b0, 7);
        tick("rst_final7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 1, 1, 0, 0, m_rcon));
        m_rcon = 6'h01;
        // Reset wins over start in the same cycle
        tick("rst_vs_start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 6'h01));
        do_idle("idle_after_rst", 1'b0);

        // Session 3: start held, noise in INIT, single MSG block
        do_idle("idle_start3", 1'b1);
        gd_cnt  = 0;
        oc_cnt  = 0;
        tag_cnt = 0;
        do_init("init3_noise", 1'b1, 1'b1);
        do_absorb("single_msg", 1'b1, 1'b1, 1'b1, 1'b1);
        do_final("final3", 1'b1, 24);
        do_tag("tag3", 1'b1);
        do_idle("idle_after3", 1'b0);
        do_idle("idle_after3b", 1'b0);
        check_cnt("s3_getdata", gd_cnt, 1);
        check_cnt("s3_outc", oc_cnt, 1);
        check_cnt("s3_tag", tag_cnt, 1);
        check_cnt("s3_tag_latency", tag_cyc - blk_cyc, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
